// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: default
// geometry, capture FSM state type and per-channel trigger mode codes.
package la_pkg;

    localparam int unsigned LA_AW    = 10;
    localparam int unsigned LA_CH    = 8;
    localparam int unsigned LA_DEPTH = 1 << LA_AW;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } la_state_t;

    // Trigger mode codes; 0, 6 and 7 all mean "ignore this channel".
    localparam logic [2:0] TM_IGNORE = 3'd0;
    localparam logic [2:0] TM_LOW    = 3'd1;
    localparam logic [2:0] TM_HIGH   = 3'd2;
    localparam logic [2:0] TM_RISE   = 3'd3;
    localparam logic [2:0] TM_FALL   = 3'd4;
    localparam logic [2:0] TM_ANY    = 3'd5;

    // Single-channel trigger condition. Edge modes need a valid previous
    // sample; an ignored channel always matches so it drops out of the AND.
    function automatic logic chan_match(
        input logic [2:0] mode,
        input logic       cur,
        input logic       prev,
        input logic       prev_ok
    );
        logic m;
        case (mode)
            TM_LOW:  m = ~cur;
            TM_HIGH: m = cur;
            TM_RISE: m = prev_ok & ~prev & cur;
            TM_FALL: m = prev_ok & prev & ~cur;
            TM_ANY:  m = prev_ok & (prev ^ cur);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/la_trig_match.sv
// Trigger evaluator: holds the previously captured sample and compares the
// current probe word against it per channel, producing the AND-ed hit.
module la_trig_match
    import la_pkg::*;
#(
    parameter int unsigned CH = LA_CH
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            sample,
    input  logic [CH-1:0]   din,
    input  logic [3*CH-1:0] trig_mode,
    output logic            hit
);

    logic [CH-1:0] prev;
    logic          prev_ok;
    logic          prev_use;

    // An arm in this cycle makes the current sample the first of a new
    // capture, so the stored sample must not count for edge detection.
    always_comb begin
        prev_use = prev_ok & ~clear;
        hit      = 1'b1;
        for (int unsigned n = 0; n < CH; n++) begin
            if (!chan_match(trig_mode[3*n +: 3], din[n], prev[n], prev_use)) begin
                hit = 1'b0;
            end
        end
    end

    // Previous-sample register; invalidated by arm unless a sample lands too.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (sample) begin
            prev    <= din;
            prev_ok <= 1'b1;
        end else if (clear) begin
            prev_ok <= 1'b0;
        end
    end

endmodule

// File: rtl/la_sample_ctrl.sv
// Capture engine: writes sampled probe words into the display ring RAM,
// waits for a trigger after filling the pre-trigger window, then captures
// the post-trigger window and publishes the frame origin.
module la_sample_ctrl
    import la_pkg::*;
#(
    parameter int unsigned AW = LA_AW,
    parameter int unsigned CH = LA_CH
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            sample_en,
    input  logic [CH-1:0]   din,
    input  logic            arm,
    input  logic            force_trig,
    input  logic [3*CH-1:0] trig_mode,
    input  logic [AW-1:0]   pre_num,
    output logic [CH-1:0]   wr_data,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [AW-1:0]   start_addr,
    output logic            trigger_en,
    output logic            done
);

    // pre_num is AW bits wide, so it can never exceed DEPTH-1 and the
    // min(pre_num, DEPTH-1) clamp is the identity.
    localparam logic [AW-1:0] LAST_IDX = '1;

    la_state_t     state, state_nx, st_eff;
    logic [AW-1:0] pre_q, pre_q_nx, pq_eff, post_q_eff;
    logic [AW-1:0] pre_cnt, pre_cnt_nx, pre_cnt_eff, pre_inc;
    logic [AW-1:0] post_cnt, post_cnt_nx, post_cnt_eff, post_inc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] start_pend, start_pend_nx;
    logic          force_pend, force_pend_nx, fp_eff;
    logic          capture;
    logic          hit;
    logic          trig_now;

    la_trig_match #(
        .CH(CH)
    ) u_match (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .clear    (arm),
        .sample   (capture),
        .din      (din),
        .trig_mode(trig_mode),
        .hit      (hit)
    );

    // Next-state logic. An arm is folded in first as an "effective" state
    // so that a sample arriving in the same cycle belongs to the new capture.
    always_comb begin
        st_eff       = state;
        pq_eff       = pre_q;
        pre_cnt_eff  = pre_cnt;
        post_cnt_eff = post_cnt;
        fp_eff       = force_pend;
        if (arm) begin
            pq_eff       = pre_num;
            st_eff       = (pre_num == '0) ? S_WAIT : S_PRE;
            pre_cnt_eff  = '0;
            post_cnt_eff = '0;
            fp_eff       = 1'b0;
        end

        post_q_eff = LAST_IDX - pq_eff;
        pre_inc    = pre_cnt_eff + AW'(1);
        post_inc   = post_cnt_eff + AW'(1);
        trig_now   = hit | force_trig | fp_eff;

        state_nx      = st_eff;
        pre_q_nx      = pq_eff;
        pre_cnt_nx    = pre_cnt_eff;
        post_cnt_nx   = post_cnt_eff;
        start_pend_nx = start_pend;
        force_pend_nx = 1'b0;
        capture       = 1'b0;

        case (st_eff)
            S_PRE: begin
                if (sample_en) begin
                    capture    = 1'b1;
                    pre_cnt_nx = pre_inc;
                    if (pre_inc == pq_eff) begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                force_pend_nx = fp_eff | force_trig;
                if (sample_en) begin
                    capture = 1'b1;
                    if (trig_now) begin
                        start_pend_nx = wr_ptr - pq_eff;
                        post_cnt_nx   = '0;
                        force_pend_nx = 1'b0;
                        state_nx      = (post_q_eff == '0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST: begin
                if (sample_en) begin
                    capture     = 1'b1;
                    post_cnt_nx = post_inc;
                    if (post_inc == post_q_eff) begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
            end
        endcase
    end

    // FSM state, window sizes, counters and the ring write pointer.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pre_q      <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            start_pend <= '0;
            force_pend <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            state      <= state_nx;
            pre_q      <= pre_q_nx;
            pre_cnt    <= pre_cnt_nx;
            post_cnt   <= post_cnt_nx;
            start_pend <= start_pend_nx;
            force_pend <= force_pend_nx;
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // Registered RAM write port: one cycle after a captured sample tick.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
        end else begin
            wr_en <= capture;
            if (capture) begin
                wr_data <= din;
                wr_addr <= wr_ptr;
            end
        end
    end

    // Frame origin is published on entry to S_DONE so it is already valid
    // while done is high, and is left alone by restarts.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            start_addr <= '0;
        end else if (state_nx == S_DONE) begin
            start_addr <= start_pend_nx;
        end
    end

    assign trigger_en = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule
